systolic_matmul_engine: RTL and testbench
=========================================

Name: systolic_matmul_engine

Overview:
Parametrised N×N output-stationary systolic matrix multiplier with internal input skew buffers, control FSM, and valid/ready handshakes on both input and output. It computes C = A·B, or C += A·B in accumulate mode, for arbitrary N, data width and signedness. Results are held until the consumer accepts them. It is the successor to the fixed 4×4, 8-bit, fire-and-forget top level, and sits between the matrix load buffers and the result writeback path.

Parameters:
N, 4, matrix dimension; legal range 2..64.
DATA_W, 8, width of each A/B element.
ACC_W, 32, width of each C accumulator; must be ≥ 2*DATA_W + clog2(N).
SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands.

Ports:
i_clk  in  1  clock
i_arst  in  1  asynchronous reset, active-high
i_a  in  N*N*DATA_W  matrix A, packed [row][col][DATA_W]
i_b  in  N*N*DATA_W  matrix B, packed [row][col][DATA_W]
i_accumulate  in  1  sampled with the input handshake; 1 = add onto current C, 0 = clear C first
i_inValid  in  1  A/B operands valid
o_inReady  out  1  block can accept operands
o_c  out  N*N*ACC_W  result C, packed [row][col][ACC_W]
o_outValid  out  1  o_c holds a completed result
i_outReady  in  1  consumer accepts o_c
o_busy  out  1  high in COMPUTE state

Behaviour:
- Reset (i_arst high, asynchronous):
  - state = IDLE; all accumulators, skew registers and the counter go to 0.
  - o_c = 0, o_outValid = 0, o_busy = 0.
  - o_inReady = 1 as soon as reset deasserts.
- Parameters are checked at elaboration; an illegal N or ACC_W raises $error.
- Input handshake: operands are accepted at a rising edge where i_inValid & o_inReady.
  - o_inReady = (state==IDLE) | (state==DONE & i_outReady). This path is combinational from i_outReady.
  - i_inValid while o_inReady is low is ignored; operands need not be held stable after acceptance.
- On acceptance:
  - Row skew register i loads A row i, elements in k order, preceded by i zero slots.
  - Column skew register j loads B column j, elements in k order, preceded by j zero slots. Each register is (2N-1) slots deep.
  - If i_accumulate == 0 all accumulators clear; if 1 they keep their current values.
  - Counter = 0; state goes to COMPUTE.
- COMPUTE:
  - Each cycle the skew registers shift one slot; slot 0 feeds column-0 PEs (A) and row-0 PEs (B).
  - PE(i,j) forwards a right and b down through registers and does acc += a*b. Any product with a zero-padded slot is 0.
  - The counter increments each cycle. When counter == 3N-3 (last MAC into PE(N-1,N-1)), state goes to DONE on the next edge.
- Latency: o_outValid rises exactly 3N-2 cycles after the accepting edge (N=4: 10; N=8: 22; N=2: 4).
- DONE:
  - o_outValid = 1; o_c is stable and equals the accumulators.
  - o_outValid stays high, with o_c unchanged, until i_outReady is sampled high.
  - On i_outReady: go to IDLE; if i_inValid is also high that edge, go straight to COMPUTE (back-to-back, no bubble).
- o_c is don't-care while o_outValid is low. Benches compare only at o_outValid & i_outReady.
- Arithmetic:
  - Each product is DATA_W×DATA_W → 2*DATA_W bits, signed or unsigned per SIGNED.
  - Products are sign- or zero-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W with no saturation; this includes accumulate-mode chains.
- Counter width is clog2(3N). No state is reachable other than IDLE, COMPUTE and DONE; a default branch returns to IDLE.
- Reset mid-COMPUTE or mid-DONE aborts the operation; the pending result is discarded.

Test Plan:
1. N=4, A = identity, B = 1..16 row-major, i_outReady=1 → o_outValid high exactly 10 cycles after the accepting edge for 1 cycle; o_c == B.
2. N=4 operand extremes:
   - SIGNED=0, all elements 255 → every c = 260100.
   - SIGNED=1, all elements -128 → every c = 65536.
   - SIGNED=1, A all -128, B all 127 → every c = -65024.
3. Accumulate: op1 A=B=all 1s (i_accumulate=0) then op2 the same with i_accumulate=1, output accepted in between → results 4 and then 8 in every element.
4. Backpressure: i_outReady held low for 20 cycles in DONE → o_c and o_outValid stable, o_inReady low, and i_inValid pulses ignored. Then raise i_outReady and i_inValid together → new op accepted that edge, its result correct, and o_outValid rises 10 cycles later.
5. Reset asserted asynchronously at counter == 5 → o_c = 0, o_outValid = 0, o_busy = 0 immediately; o_inReady = 1 after release; the next op (test 1 vectors) is correct.
6. N=2 and N=8, SIGNED 0/1, 200 random ops with random i_outReady stalls → bit-exact against a reference model; latency 4 / 22 cycles.

Source files
------------

// File: rtl/systolic_matmul_engine.sv
// systolic_matmul_engine: N x N output-stationary systolic matrix multiplier.
// Computes C = A*B (or C += A*B) with internal input skew buffers, a three-state
// control FSM and valid/ready handshakes on the operand and result sides.
module systolic_matmul_engine #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned SIGNED = 0
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic [N*N*DATA_W-1:0] i_a,
    input  logic [N*N*DATA_W-1:0] i_b,
    input  logic                  i_accumulate,
    input  logic                  i_inValid,
    output logic                  o_inReady,
    output logic [N*N*ACC_W-1:0]  o_c,
    output logic                  o_outValid,
    input  logic                  i_outReady,
    output logic                  o_busy
);

    localparam int unsigned SLOTS = 2 * N - 1;
    localparam int unsigned CNT_W = $clog2(3 * N);
    // Counter value at which the final MAC lands in PE(N-1,N-1).
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(3 * N - 3);

    if (N < 2 || N > 64) begin : g_bad_n
        $error("systolic_matmul_engine: N must be in 2..64");
    end
    if (ACC_W < 2 * DATA_W + $clog2(N)) begin : g_bad_acc
        $error("systolic_matmul_engine: ACC_W must be >= 2*DATA_W + clog2(N)");
    end

    typedef enum logic [1:0] {
        StIdle,
        StCompute,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Skew registers: slot 0 is the head that feeds the array edge.
    logic [DATA_W-1:0]   skew_a_q [N][SLOTS];
    logic [DATA_W-1:0]   skew_a_d [N][SLOTS];
    logic [DATA_W-1:0]   skew_b_q [N][SLOTS];
    logic [DATA_W-1:0]   skew_b_d [N][SLOTS];

    // a_pipe[i][j] is the a value PE(i,j) forwards right; b_pipe[i][j] the b it forwards down.
    logic [DATA_W-1:0]   a_pipe_q [N][N-1];
    logic [DATA_W-1:0]   a_pipe_d [N][N-1];
    logic [DATA_W-1:0]   b_pipe_q [N-1][N];
    logic [DATA_W-1:0]   b_pipe_d [N-1][N];

    logic [ACC_W-1:0]    acc_q [N][N];
    logic [ACC_W-1:0]    acc_d [N][N];

    logic [DATA_W-1:0]   a_in [N][N];
    logic [DATA_W-1:0]   b_in [N][N];

    logic                accept;

    // Full-precision product extended to the accumulator width.
    function automatic logic [ACC_W-1:0] mac_prod(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] p;
        if (SIGNED != 0) begin
            p = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
            return {{(ACC_W - 2 * DATA_W){p[2*DATA_W-1]}}, p};
        end else begin
            p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
            return {{(ACC_W - 2 * DATA_W){1'b0}}, p};
        end
    endfunction

    // PE operand routing: edge PEs read the skew heads, inner PEs read neighbours.
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_a_edge
                assign a_in[i][j] = skew_a_q[i][0];
            end else begin : g_a_inner
                assign a_in[i][j] = a_pipe_q[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in[i][j] = skew_b_q[j][0];
            end else begin : g_b_inner
                assign b_in[i][j] = b_pipe_q[i-1][j];
            end
            assign o_c[(i*N+j)*ACC_W +: ACC_W] = acc_q[i][j];
        end
    end

    assign o_inReady  = (state_q == StIdle) | ((state_q == StDone) & i_outReady);
    assign accept     = i_inValid & o_inReady;
    assign o_outValid = (state_q == StDone);
    assign o_busy     = (state_q == StCompute);

    // Control FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (i_inValid) state_d = StCompute;
            end
            StCompute: begin
                if (cnt_q == LAST_CNT) state_d = StDone;
            end
            StDone: begin
                if (i_outReady) state_d = i_inValid ? StCompute : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: load on acceptance, shift and MAC while computing.
    always_comb begin
        cnt_d    = cnt_q;
        skew_a_d = skew_a_q;
        skew_b_d = skew_b_q;
        a_pipe_d = a_pipe_q;
        b_pipe_d = b_pipe_q;
        acc_d    = acc_q;
        if (accept) begin
            cnt_d = '0;
            for (int i = 0; i < N; i++) begin
                for (int s = 0; s < SLOTS; s++) begin
                    skew_a_d[i][s] = '0;
                    skew_b_d[i][s] = '0;
                end
                // Register i is delayed by i leading zero slots.
                for (int k = 0; k < N; k++) begin
                    skew_a_d[i][i+k] = i_a[(i*N+k)*DATA_W +: DATA_W];
                    skew_b_d[i][i+k] = i_b[(k*N+i)*DATA_W +: DATA_W];
                end
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N - 1; j++) begin
                    a_pipe_d[i][j] = '0;
                    b_pipe_d[j][i] = '0;
                end
            end
            if (!i_accumulate) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        acc_d[i][j] = '0;
                    end
                end
            end
        end else if (state_q == StCompute) begin
            cnt_d = cnt_q + CNT_W'(1);
            for (int i = 0; i < N; i++) begin
                for (int s = 0; s < SLOTS - 1; s++) begin
                    skew_a_d[i][s] = skew_a_q[i][s+1];
                    skew_b_d[i][s] = skew_b_q[i][s+1];
                end
                skew_a_d[i][SLOTS-1] = '0;
                skew_b_d[i][SLOTS-1] = '0;
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc_d[i][j] = acc_q[i][j] + mac_prod(a_in[i][j], b_in[i][j]);
                    if (j < N - 1) a_pipe_d[i][j] = a_in[i][j];
                    if (i < N - 1) b_pipe_d[i][j] = b_in[i][j];
                end
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            for (int i = 0; i < N; i++) begin
                for (int s = 0; s < SLOTS; s++) begin
                    skew_a_q[i][s] <= '0;
                    skew_b_q[i][s] <= '0;
                end
                for (int j = 0; j < N; j++) begin
                    acc_q[i][j] <= '0;
                end
                for (int j = 0; j < N - 1; j++) begin
                    a_pipe_q[i][j] <= '0;
                    b_pipe_q[j][i] <= '0;
                end
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            skew_a_q <= skew_a_d;
            skew_b_q <= skew_b_d;
            a_pipe_q <= a_pipe_d;
            b_pipe_q <= b_pipe_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Bench for systolic_matmul_engine: six instances (N = 4/2/8, both signedness)
// checked against a plain matrix-product model.
module tb_systolic_matmul_engine;

    localparam int NUM = 6;
    localparam int NS [NUM] = '{4, 4, 2, 8, 2, 8};
    localparam int SG [NUM] = '{0, 1, 0, 1, 1, 0};

    logic              clk = 1'b0;
    logic              arst = 1'b1;
    logic [511:0]      a_flat = '0;
    logic [511:0]      b_flat = '0;
    logic              accumulate = 1'b0;
    logic [NUM-1:0]    in_valid = '0;
    logic [NUM-1:0]    out_ready = '0;
    wire  [NUM-1:0]    in_ready;
    wire  [NUM-1:0]    out_valid;
    wire  [NUM-1:0]    busy;
    wire  [2047:0]     c_all [NUM];

    int errors = 0;
    int checks = 0;

    int ea [8][8];
    int eb [8][8];
    logic [31:0] ref_c [NUM][8][8];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NUM; g++) begin : g_dut
        localparam int unsigned GN = NS[g];
        wire [GN*GN*32-1:0] c_w;
        systolic_matmul_engine #(
            .N      (GN),
            .DATA_W (8),
            .ACC_W  (32),
            .SIGNED (SG[g])
        ) u_dut (
            .i_clk        (clk),
            .i_arst       (arst),
            .i_a          (a_flat[GN*GN*8-1:0]),
            .i_b          (b_flat[GN*GN*8-1:0]),
            .i_accumulate (accumulate),
            .i_inValid    (in_valid[g]),
            .o_inReady    (in_ready[g]),
            .o_c          (c_w),
            .o_outValid   (out_valid[g]),
            .i_outReady   (out_ready[g]),
            .o_busy       (busy[g])
        );
        assign c_all[g] = 2048'(c_w);
    end

    function automatic logic [31:0] get_c(input int sel, input int r, input int c);
        return c_all[sel][(r*NS[sel]+c)*32 +: 32];
    endfunction

    task automatic pack(input int n);
        a_flat = '0;
        b_flat = '0;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                a_flat[(r*n+c)*8 +: 8] = 8'(ea[r][c]);
                b_flat[(r*n+c)*8 +: 8] = 8'(eb[r][c]);
            end
        end
    endtask

    task automatic rand_mats(input int sel);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (SG[sel] != 0) begin
                    ea[r][c] = int'($urandom_range(0, 255)) - 128;
                    eb[r][c] = int'($urandom_range(0, 255)) - 128;
                end else begin
                    ea[r][c] = int'($urandom_range(0, 255));
                    eb[r][c] = int'($urandom_range(0, 255));
                end
            end
        end
    endtask

    task automatic fill_mats(input int av, input int bv);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                ea[r][c] = av;
                eb[r][c] = bv;
            end
        end
    endtask

    task automatic ident_mats();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                ea[r][c] = (r == c) ? 1 : 0;
                eb[r][c] = r * 4 + c + 1;
            end
        end
    endtask

    // Reference: C = (accum ? C : 0) + A*B, wrapping at 32 bits.
    function automatic void model_update(input int sel, input bit accum);
        logic [31:0] s;
        for (int r = 0; r < NS[sel]; r++) begin
            for (int c = 0; c < NS[sel]; c++) begin
                s = accum ? ref_c[sel][r][c] : 32'd0;
                for (int k = 0; k < NS[sel]; k++) begin
                    s = s + 32'(ea[r][k] * eb[k][c]);
                end
                ref_c[sel][r][c] = s;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int g = 0; g < NUM; g++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    ref_c[g][r][c] = '0;
    endfunction

    function automatic int mism(input int sel, input bit use_fixed, input logic [31:0] fixed);
        int cnt;
        logic [31:0] exp_v;
        cnt = 0;
        for (int r = 0; r < NS[sel]; r++) begin
            for (int c = 0; c < NS[sel]; c++) begin
                exp_v = use_fixed ? fixed : ref_c[sel][r][c];
                if (get_c(sel, r, c) !== exp_v) cnt++;
            end
        end
        return cnt;
    endfunction

    // One operation: accept, time the result, optional stall, then consume it.
    task automatic run_op(input int sel, input bit accum, input int stall, input bit use_fixed,
                          input logic [31:0] fixed, output int lat, output int bad);
        pack(NS[sel]);
        accumulate     = accum;
        in_valid[sel]  = 1'b1;
        out_ready[sel] = 1'b0;
        @(posedge clk); #1;
        in_valid[sel] = 1'b0;
        model_update(sel, accum);
        lat = 0;
        while (!out_valid[sel] && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        repeat (stall) begin
            @(posedge clk); #1;
        end
        out_ready[sel] = 1'b1;
        #1;
        bad = mism(sel, use_fixed, fixed);
        if (!out_valid[sel]) bad++;
        @(posedge clk); #1;
        out_ready[sel] = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== '0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (busy !== '0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if (in_ready !== {NUM{1'b1}}) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want all ones", in_ready);
        end
        checks++;
        if (c_all[0] !== '0) begin
            errors++;
            $display("FAIL reset_c: got nonzero want 0");
        end
    endtask

    task automatic test_identity();
        int lat, bad;
        ident_mats();
        run_op(0, 1'b0, 0, 1'b0, 32'd0, lat, bad);
        checks++;
        if (lat !== 10) begin
            errors++;
            $display("FAIL identity_latency: got %0d want 10", lat);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL identity_result: got %0d bad elements want 0", bad);
        end
        checks++;
        if (out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL identity_valid_drop: got %b want 0", out_valid[0]);
        end
    endtask

    task automatic test_extremes();
        int lat, bad;
        fill_mats(255, 255);
        run_op(0, 1'b0, 0, 1'b1, 32'd260100, lat, bad);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL extreme_u255: got %0d bad elements want 0", bad);
        end
        fill_mats(-128, -128);
        run_op(1, 1'b0, 1, 1'b1, 32'd65536, lat, bad);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL extreme_s128sq: got %0d bad elements want 0", bad);
        end
        fill_mats(-128, 127);
        run_op(1, 1'b0, 0, 1'b1, 32'hFFFF_0200, lat, bad);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL extreme_smix: got %0d bad elements want 0 (expect -65024)", bad);
        end
    endtask

    task automatic test_accumulate();
        int lat, bad;
        fill_mats(1, 1);
        run_op(0, 1'b0, 0, 1'b1, 32'd4, lat, bad);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL accum_first: got %0d bad elements want 0 (expect 4)", bad);
        end
        run_op(0, 1'b1, 2, 1'b1, 32'd8, lat, bad);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL accum_second: got %0d bad elements want 0 (expect 8)", bad);
        end
    endtask

    task automatic test_backpressure();
        int lat, bad, stall_bad;
        rand_mats(0);
        pack(4);
        accumulate   = 1'b0;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        model_update(0, 1'b0);
        lat = 0;
        while (!out_valid[0] && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 10) begin
            errors++;
            $display("FAIL bp_latency1: got %0d want 10", lat);
        end
        // Held result must survive ignored operand pulses.
        stall_bad = 0;
        for (int t = 0; t < 20; t++) begin
            rand_mats(0);
            pack(4);
            in_valid[0] = t[0];
            #1;
            if (!out_valid[0] || in_ready[0] || busy[0] || mism(0, 1'b0, 32'd0) != 0)
                stall_bad++;
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        checks++;
        if (stall_bad !== 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d bad stall cycles want 0", stall_bad);
        end
        // Consume and launch the next op (accumulating) on the same edge.
        rand_mats(0);
        pack(4);
        accumulate   = 1'b1;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        #1;
        checks++;
        if (in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_in_ready: got %b want 1", in_ready[0]);
        end
        checks++;
        bad = mism(0, 1'b0, 32'd0);
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_result1: got %0d bad elements want 0", bad);
        end
        @(posedge clk); #1;
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        model_update(0, 1'b1);
        lat = 0;
        while (!out_valid[0] && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 10) begin
            errors++;
            $display("FAIL bp_latency2: got %0d want 10", lat);
        end
        out_ready[0] = 1'b1;
        #1;
        checks++;
        bad = mism(0, 1'b0, 32'd0);
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_result2: got %0d bad elements want 0", bad);
        end
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat, bad;
        fill_mats(3, 5);
        pack(4);
        accumulate  = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy_before: got %b want 1", busy[0]);
        end
        arst = 1'b1;
        #1;
        checks++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_flags: got valid=%b busy=%b want 0 0", out_valid[0], busy[0]);
        end
        checks++;
        if (c_all[0] !== '0) begin
            errors++;
            $display("FAIL rst_mid_c: got nonzero want 0");
        end
        #2;
        arst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_in_ready: got %b want 1", in_ready[0]);
        end
        @(posedge clk); #1;
        ident_mats();
        run_op(0, 1'b1, 0, 1'b0, 32'd0, lat, bad);
        checks++;
        if (lat !== 10 || bad !== 0) begin
            errors++;
            $display("FAIL rst_mid_next_op: got lat=%0d bad=%0d want 10 0", lat, bad);
        end
    endtask

    task automatic test_random();
        int lat, bad, sel;
        int sels [4] = '{2, 4, 3, 5};
        for (int s = 0; s < 4; s++) begin
            sel = sels[s];
            for (int op = 0; op < 50; op++) begin
                rand_mats(sel);
                run_op(sel, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0, 32'd0,
                       lat, bad);
                checks++;
                if (lat !== 3 * NS[sel] - 2) begin
                    errors++;
                    $display("FAIL random_latency inst=%0d op=%0d: got %0d want %0d",
                             sel, op, lat, 3 * NS[sel] - 2);
                end
                checks++;
                if (bad !== 0) begin
                    errors++;
                    $display("FAIL random_result inst=%0d op=%0d: got %0d bad elements want 0",
                             sel, op, bad);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        arst = 1'b0;
        #1;
        test_reset();
        @(posedge clk); #1;
        test_identity();
        test_extremes();
        test_accumulate();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
